// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin shared 8-bit adder with two-stage pipeline

// Combinational modulo-256 adder; the carry-out is intentionally discarded.
module adder14 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_sum,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  logic              s1_valid_q;
  logic [7:0]        s1_a_q;
  logic [7:0]        s1_b_q;
  logic [ID_W-1:0]   s1_id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic              rsp_valid_q;
  logic [7:0]        rsp_sum_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [CNT_W-1:0]  op_count_q;

  logic              adv1;
  logic              adv2;
  logic              found;
  logic [ID_W-1:0]   gidx;
  logic [ID_W-1:0]   scan_idx;
  int                scan_j;
  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [7:0]        adder_sum;

  // The adder only ever sees the stage-1 operand registers.
  adder14 u_adder (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .sum_o (adder_sum)
  );

  assign adv2 = ~rsp_valid_q | rsp_ready;
  assign adv1 = ~s1_valid_q | adv2;

  // Round-robin scan from ptr_q; grant only when stage 1 can accept and not in reset.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    grant    = '0;
    scan_j   = 0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= NREQ) scan_j = scan_j - NREQ;
      scan_idx = scan_j[ID_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        gidx  = scan_idx;
      end
    end
    if (rst_n && adv1 && found) grant[gidx] = 1'b1;
  end

  assign xfer  = |(req_valid & grant);
  assign ptr_d = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);

  // Pipeline registers, round-robin pointer and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      if (adv1) begin
        if (xfer) begin
          s1_valid_q <= 1'b1;
          s1_a_q     <= req_a[8*gidx +: 8];
          s1_b_q     <= req_b[8*gidx +: 8];
          s1_id_q    <= gidx;
          ptr_q      <= ptr_d;
        end else begin
          s1_valid_q <= 1'b0;
        end
      end
      if (adv2) begin
        rsp_valid_q <= s1_valid_q;
        // Keep the last sum/id visible when the response slot empties.
        if (s1_valid_q) begin
          rsp_sum_q <= adder_sum;
          rsp_id_q  <= s1_id_q;
        end
      end
      if (rsp_valid_q && rsp_ready) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = s1_valid_q | rsp_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard and vector-table bench for adder_share_arb
module tb_adder_share_arb;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_sum;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  adder_share_arb #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [7:0]      sum;
  } exp_t;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  sum;
  } vec_t;

  exp_t            exp_q[$];
  int              grant_log[$];
  logic [7:0]      exp_sum_r[NREQ];
  logic [CNT_W-1:0] model_cnt;
  int              checks = 0;
  int              failures = 0;
  int              n_rsp = 0;
  int              n_xfer = 0;
  bit              hold_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    exp_sum_r[i]    = s;
    req_valid[i]    = 1'b1;
  endtask

  // One clock: observe handshakes at negedge, update stimulus 1 time unit after posedge.
  task automatic tick();
    logic [NREQ-1:0] xmask;
    exp_t e;
    xmask = '0;
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = ID_W'(i);
          e.sum = exp_sum_r[i];
          exp_q.push_back(e);
          grant_log.push_back(i);
          xmask[i] = 1'b1;
          n_xfer++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        end
        model_cnt = model_cnt + CNT_W'(1);
        n_rsp++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) check("op_count", 32'(op_count), 32'(model_cnt));
    if (!hold_mode) req_valid = req_valid & ~xmask;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    model_cnt = '0;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_valid != 0 || exp_q.size() != 0 || busy) && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(n < 40), 32'd1);
  endtask

  vec_t vecs[6];
  logic [7:0] held_sum;
  logic [ID_W-1:0] held_id;
  int rsp_base;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_cnt = '0;
    for (int i = 0; i < NREQ; i++) exp_sum_r[i] = '0;

    vecs[0] = '{id: 2, a: 8'h12, b: 8'h34, sum: 8'h46};
    vecs[1] = '{id: 1, a: 8'd200, b: 8'd100, sum: 8'd44};
    vecs[2] = '{id: 3, a: 8'hFF, b: 8'h01, sum: 8'h00};
    vecs[3] = '{id: 0, a: 8'h80, b: 8'h80, sum: 8'h00};
    vecs[4] = '{id: 2, a: 8'h0F, b: 8'h01, sum: 8'h10};
    vecs[5] = '{id: 1, a: 8'h7F, b: 8'h7F, sum: 8'hFE};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);

    // Single request from requester 2, latency check.
    set_req(2, 8'h12, 8'h34, 8'h46);
    #2;
    check("single_grant", 32'(req_ready), 32'b0100);
    tick();
    check("single_lat1_valid", 32'(rsp_valid), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("single_lat2_valid", 32'(rsp_valid), 32'd1);
    check("single_lat2_sum", 32'(rsp_sum), 32'h46);
    check("single_lat2_id", 32'(rsp_id), 32'd2);
    tick();
    check("single_count", 32'(op_count), 32'd1);
    check("single_hold_sum", 32'(rsp_sum), 32'h46);

    // Table of single operations including overflow cases.
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum);
      wait_idle("vec_drain");
    end

    // All requesters continuously from reset: round-robin order, 1 op/cycle.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 8'(16 * i + 1), 8'(i + 8'h70), 8'(16 * i + 1 + i + 8'h70));
    end
    hold_mode = 1;
    rsp_base = n_rsp;
    repeat (8) tick();
    hold_mode = 0;
    req_valid = '0;
    check("stream_rsp_count", 32'(n_rsp - rsp_base), 32'd6);
    wait_idle("stream_drain");
    check("stream_grants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check("stream_order", 32'(grant_log[i]), 32'(i % NREQ));
    end

    // Backpressure with two ops in flight.
    rsp_ready = 1'b0;
    rsp_base = n_rsp;
    set_req(0, 8'h21, 8'h03, 8'h24);
    set_req(1, 8'hF0, 8'h20, 8'h10);
    tick();
    tick();
    set_req(2, 8'h05, 8'h06, 8'h0B);
    #2;
    check("bp_ready_zero", 32'(req_ready), 32'd0);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    held_sum = rsp_sum;
    held_id  = rsp_id;
    check("bp_first_id", 32'(held_id), 32'd0);
    repeat (3) begin
      tick();
      check("bp_hold_sum", 32'(rsp_sum), 32'(held_sum));
      check("bp_hold_id", 32'(rsp_id), 32'(held_id));
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_release_grant", 32'(req_ready), 32'b0100);
    tick();
    check("bp_second_valid", 32'(rsp_valid), 32'd1);
    check("bp_second_id", 32'(rsp_id), 32'd1);
    wait_idle("bp_drain");
    check("bp_rsp_count", 32'(n_rsp - rsp_base), 32'd3);

    // Reset while both stages hold an op; the pointer must return to 0.
    rsp_ready = 1'b0;
    set_req(0, 8'h01, 8'h01, 8'h02);
    set_req(1, 8'h02, 8'h02, 8'h04);
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    req_valid = '0;
    do_reset();
    check("mid_reset_valid", 32'(rsp_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_sum", 32'(rsp_sum), 32'd0);
    check("mid_reset_id", 32'(rsp_id), 32'd0);
    check("mid_reset_count", 32'(op_count), 32'd0);
    rsp_ready = 1'b1;
    repeat (4) begin
      tick();
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    set_req(1, 8'h10, 8'h20, 8'h30);
    set_req(3, 8'h40, 8'h50, 8'h90);
    #2;
    check("ptr_after_reset", 32'(req_ready), 32'b0010);
    wait_idle("post_reset_drain");

    // Counter wrap: 17 responses on a 4-bit counter read back as 1.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'(3), 8'(i + 3));
    hold_mode = 1;
    n_xfer = 0;
    begin
      int n;
      n = 0;
      while (n_xfer < 17 && n < 60) begin
        tick();
        n++;
      end
      check("wrap_xfer_bound", 32'(n_xfer), 32'd17);
    end
    hold_mode = 0;
    req_valid = '0;
    wait_idle("wrap_drain");
    check("wrap_count", 32'(op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
Shares a single instance of the 8-bit adder `adder14` among NREQ independent requesters. `adder14` computes a modulo-256 sum with no carry-out.
- Arbitration: round-robin among pending requests.
- Datapath: two-stage pipeline (operand register, then result register) with a single valid/ready response port tagged by requester ID.
- Placement: sits between user-project request logic and the adder, so the combinational adder is never driven by more than one source.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must equal clog2(NREQ)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
req_valid  in  NREQ  per-requester request valid
req_a  in  NREQ*8  operand A, requester i in bits [8i+7:8i]
req_b  in  NREQ*8  operand B, same packing
req_ready  out  NREQ  one-hot grant; transfer for requester i = req_valid[i] & req_ready[i]
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_sum  out  8  (a+b) mod 256
rsp_id  out  ID_W  index of requester that issued the operation
busy  out  1  s1_valid | rsp_valid
op_count  out  CNT_W  completed responses (rsp handshakes), wraps at 2^CNT_W

Behaviour:
- Reset (rst_n=0 at clk edge): s1_valid=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rr pointer=0, op_count=0.
  - req_ready is 0 throughout reset.
  - In-flight operations are discarded; no partial response is emitted after reset releases.
- Pipeline enables:
  - adv2 = ~rsp_valid | rsp_ready
  - adv1 = ~s1_valid | adv2
- Arbitration (combinational):
  - If adv1=1, scan req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit i gets req_ready[i]=1; every other req_ready bit is 0.
  - If adv1=0 or no request is pending, req_ready is all zeros.
  - req_ready may depend on req_valid. Requesters must hold req_a/req_b/req_valid stable until transferred.
- On transfer from requester i:
  - s1_a, s1_b and s1_id are loaded with requester i's operands and i.
  - s1_valid<=1.
  - ptr<=(i+1) mod NREQ.
  - ptr is unchanged when no transfer occurs.
- If adv1=1 and no transfer occurs: s1_valid<=0.
- Stage 2:
  - `adder14` inputs are driven only from s1_a and s1_b.
  - When adv2=1: rsp_valid<=s1_valid, rsp_sum<=adder14 sum, rsp_id<=s1_id.
  - rsp_sum and rsp_id hold their last value when rsp_valid falls.
- Latency and throughput:
  - Transfer at edge N gives rsp_valid=1 after edge N+1 (result visible in the cycle following the 2nd edge, counting the accept edge as the 1st).
  - Sustained throughput is one op/cycle while rsp_ready=1.
- Backpressure:
  - rsp_valid=1 with rsp_ready=0 freezes stage 2. It also freezes stage 1 if s1_valid=1, after which req_ready is all zeros.
  - With at most 2 ops in flight, no op is ever dropped or duplicated.
  - Release: rsp_ready=1 drains 1 op/cycle and re-enables grants in the same cycle.
- Simultaneous events:
  - A response handshake and a new grant in the same cycle are both legal and both occur.
  - A request asserted in the same cycle its predecessor transfers may be granted next cycle.
- op_count: increments by 1 on each rsp_valid&rsp_ready edge; wraps 2^CNT_W-1 -> 0.
- Overflow: the sum carry is discarded (200+100 -> 44). No carry or overflow flag is produced.
- Fairness: any requester holding req_valid is granted within NREQ transfers.

Test Plan:
- Single request, requester 2 a=0x12 b=0x34, rsp_ready=1 -> req_ready=4'b0100 that cycle; 2 edges later rsp_valid=1, rsp_sum=0x46, rsp_id=2; op_count=1.
- All four request continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; rsp_id sequence matches; one rsp per cycle after 2-cycle fill.
- Overflow: a=200 b=100 -> rsp_sum=44. Separately, a=0xFF b=0x01 -> rsp_sum=0x00.
- Backpressure: rsp_ready=0 with two ops in flight -> req_ready=0, rsp held stable (sum/id unchanged). Set rsp_ready=1 -> both ops delivered in order on consecutive cycles; no loss or duplicate.
- Reset mid-operation: rst_n=0 for one edge with s1_valid=1 and rsp_valid=1 -> all outputs at reset values next cycle, ptr=0, op_count=0; no stale response afterwards.
- Counter wrap with CNT_W=4: 17 responses -> op_count reads 1.
